// File: rtl/maze_pkg.sv
// Shared constants, types and packet packing for the maze-cell update link.
// Used by the transmit block here and by the display-side decoder.
package maze_pkg;

    // Grid geometry and field widths
    localparam int unsigned COLS      = 5;
    localparam int unsigned ROWS      = 4;
    localparam int unsigned X_W       = 3;
    localparam int unsigned Y_W       = 2;
    localparam int unsigned FLAG_W    = 8;

    // Packet layout: [15:13]=x, [12:11]=y, [10:8]=0, [7:0]=flags
    localparam int unsigned PKT_X_LSB = 13;
    localparam int unsigned PKT_Y_LSB = 11;
    localparam int unsigned PKT_W     = 16;

    // One buffered update as stored in the FIFO
    localparam int unsigned ENTRY_W   = X_W + Y_W + FLAG_W;

    typedef struct packed {
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [FLAG_W-1:0] flags;
    } cell_upd_t;

    // Output sequencer states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StGap  = 2'd2
    } tx_state_e;

    // Build the 16-bit link packet; the bits between y and flags are always zero.
    function automatic logic [PKT_W-1:0] maze_pack(
        input logic [X_W-1:0]    x,
        input logic [Y_W-1:0]    y,
        input logic [FLAG_W-1:0] flags
    );
        logic [PKT_W-1:0] pkt;
        pkt                     = '0;
        pkt[PKT_X_LSB +: X_W]   = x;
        pkt[PKT_Y_LSB +: Y_W]   = y;
        pkt[FLAG_W-1:0]         = flags;
        return pkt;
    endfunction

endpackage

// File: rtl/maze_pkt_fifo.sv
// Synchronous update FIFO with occupancy count. DEPTH must be a power of two
// so the read/write pointers wrap naturally. Push when full and pop when empty
// are ignored.
module maze_pkt_fifo
    import maze_pkg::*;
#(
    parameter int unsigned WIDTH = ENTRY_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/maze_packet_tx.sv
// Transmit side of the 16-bit maze-cell update link. Accepts (x, y, flags)
// updates over valid/ready, drops out-of-grid updates (counted in DROP_CNT),
// buffers the rest in a FIFO and emits one packet per DATA_VAL strobe,
// followed by GAP_CYCLES idle cycles.
// Optional feature: define MAZE_TX_DEDUP_EN to discard updates whose flags
// match the last value enqueued for the same cell.
module maze_packet_tx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned COLS       = maze_pkg::COLS,
    parameter int unsigned ROWS       = maze_pkg::ROWS
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          UPD_VALID,
    output logic                          UPD_READY,
    input  logic [maze_pkg::X_W-1:0]      UPD_X,
    input  logic [maze_pkg::Y_W-1:0]      UPD_Y,
    input  logic [maze_pkg::FLAG_W-1:0]   UPD_DATA,
    output logic [maze_pkg::PKT_W-1:0]    DATA_OUT,
    output logic                          DATA_VAL,
    output logic                          BUSY,
    output logic [7:0]                    DROP_CNT
);

    import maze_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Grid limits widened by one bit so a full-range dimension still compares correctly
    localparam logic [X_W:0] COL_LIM = COLS[X_W:0];
    localparam logic [Y_W:0] ROW_LIM = ROWS[Y_W:0];

    // Gap counter reload; unused when GAP_CYCLES is zero
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    logic             accept;
    logic             in_range;
    logic             dup;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    cell_upd_t        wr_entry;
    cell_upd_t        head;
    logic [ENTRY_W-1:0] fifo_rdata;

    tx_state_e        state;
    logic [3:0]       gap_cnt;

    // ---------------------------------------------------------------------
    // Input side
    // ---------------------------------------------------------------------

    // Ready depends only on the registered occupancy, never on this cycle's pop
    assign UPD_READY = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign accept    = UPD_VALID && UPD_READY;
    assign in_range  = ({1'b0, UPD_X} < COL_LIM) && ({1'b0, UPD_Y} < ROW_LIM);
    assign push      = accept && in_range && !dup;

    assign wr_entry.x     = UPD_X;
    assign wr_entry.y     = UPD_Y;
    assign wr_entry.flags = UPD_DATA;

`ifdef MAZE_TX_DEDUP_EN
    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    logic [FLAG_W-1:0] shadow_flags [CELLS];
    logic [CELLS-1:0]  shadow_valid;
    logic [IDX_W-1:0]  cell_idx;

    // Row-major cell index; only meaningful when the update is in range
    assign cell_idx = IDX_W'(COLS * 32'(UPD_Y) + 32'(UPD_X));

    // An update repeating the last enqueued value for its cell carries no news
    always_comb begin
        dup = 1'b0;
        if (in_range && shadow_valid[cell_idx] && (shadow_flags[cell_idx] == UPD_DATA)) begin
            dup = 1'b1;
        end
    end

    // Shadow values track what was last enqueued per cell
    always_ff @(posedge CLK) begin
        if (push) begin
            shadow_flags[cell_idx] <= UPD_DATA;
        end
    end

    // Shadow valid bits start cleared so the first update to each cell always goes out
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            shadow_valid <= '0;
        end else if (push) begin
            shadow_valid[cell_idx] <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // Saturating count of updates rejected for lying outside the grid
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            DROP_CNT <= '0;
        end else if (accept && !in_range && (DROP_CNT != 8'hFF)) begin
            DROP_CNT <= DROP_CNT + 8'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Buffer
    // ---------------------------------------------------------------------

    maze_pkt_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign head       = cell_upd_t'(fifo_rdata);
    assign fifo_empty = (fifo_count == '0);

    // ---------------------------------------------------------------------
    // Output sequencer
    // ---------------------------------------------------------------------

    // The head is consumed on the same edge that loads DATA_OUT and enters SEND
    assign pop  = (state == StIdle) && !fifo_empty;
    assign BUSY = !fifo_empty || (state != StIdle);

    // IDLE -> SEND (one-cycle strobe) -> GAP (GAP_CYCLES cycles) -> IDLE
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= StIdle;
            DATA_OUT <= '0;
            DATA_VAL <= 1'b0;
            gap_cnt  <= '0;
        end else begin
            DATA_VAL <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (!fifo_empty) begin
                        DATA_OUT <= maze_pack(head.x, head.y, head.flags);
                        DATA_VAL <= 1'b1;
                        state    <= StSend;
                    end
                end
                StSend: begin
                    if (GAP_CYCLES > 0) begin
                        gap_cnt <= GAP_LAST;
                        state   <= StGap;
                    end else begin
                        state   <= StIdle;
                    end
                end
                StGap: begin
                    if (gap_cnt == '0) begin
                        state <= StIdle;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maze_packet_tx.sv
// Self-checking bench for maze_packet_tx. Expected packets are queued when an
// update is accepted and checked in order by a monitor when DATA_VAL strobes.
// Build with MAZE_TX_DEDUP_EN defined to exercise the duplicate filter.
module tb_maze_packet_tx;

    logic        CLK;
    logic        RESET;
    logic        UPD_VALID;
    logic        UPD_READY;
    logic [2:0]  UPD_X;
    logic [1:0]  UPD_Y;
    logic [7:0]  UPD_DATA;
    logic [15:0] DATA_OUT;
    logic        DATA_VAL;
    logic        BUSY;
    logic [7:0]  DROP_CNT;

    int          tests;
    int          fails;
    int          cyc;
    int          strobe_cnt;
    int          exp_drop;
    logic        prev_val;
    logic [15:0] exp_q[$];
    int          strobe_cyc_q[$];

    maze_packet_tx #(
        .FIFO_DEPTH (8),
        .GAP_CYCLES (2),
        .COLS       (5),
        .ROWS       (4)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .UPD_VALID (UPD_VALID),
        .UPD_READY (UPD_READY),
        .UPD_X     (UPD_X),
        .UPD_Y     (UPD_Y),
        .UPD_DATA  (UPD_DATA),
        .DATA_OUT  (DATA_OUT),
        .DATA_VAL  (DATA_VAL),
        .BUSY      (BUSY),
        .DROP_CNT  (DROP_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Edge counter: at a negedge, cyc is the index of the preceding posedge
    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [15:0] pack(input logic [2:0] x, input logic [1:0] y,
                                         input logic [7:0] f);
        return {x, y, 3'b000, f};
    endfunction

    // Scoreboard monitor: every strobe must match the oldest expected packet
    initial begin
        prev_val = 1'b0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                prev_val = 1'b0;
            end else begin
                if (DATA_VAL === 1'b1) begin
                    logic [15:0] exp;
                    strobe_cnt++;
                    strobe_cyc_q.push_back(cyc);
                    tests++;
                    if (prev_val === 1'b1) begin
                        fails++;
                        $display("FAIL pulse_width: DATA_VAL high again at cycle %0d, required 1-cycle strobes", cyc);
                    end
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_packet: got %h at cycle %0d, none expected", DATA_OUT, cyc);
                    end else begin
                        exp = exp_q.pop_front();
                        if (DATA_OUT !== exp) begin
                            fails++;
                            $display("FAIL packet_data: got %h, expected %h (cycle %0d)", DATA_OUT, exp, cyc);
                        end
                    end
                end
                prev_val = DATA_VAL;
            end
        end
    end

    // All stimulus and task-level checks happen 1 time unit after a negedge
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    // Present one update and hold it until accepted; leaves UPD_VALID high.
    // acc_cyc is the posedge at which the update is taken.
    task automatic send(input logic [2:0] x, input logic [1:0] y, input logic [7:0] f,
                        input bit dup, output int acc_cyc);
        int guard;
        UPD_VALID = 1'b1;
        UPD_X     = x;
        UPD_Y     = y;
        UPD_DATA  = f;
        guard     = 0;
        while (UPD_READY !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        if (UPD_READY !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: UPD_READY=%b after %0d cycles, required 1", UPD_READY, guard);
            acc_cyc = -1;
        end else begin
            acc_cyc = cyc + 1;
            // Every 2-bit row is inside a 4-row grid, so only x can be out of range
            if (x < 3'd5) begin
                if (!dup) exp_q.push_back(pack(x, y, f));
            end else if (exp_drop < 255) begin
                exp_drop++;
            end
            step();
        end
    endtask

    task automatic wait_idle();
        int guard;
        UPD_VALID = 1'b0;
        guard     = 0;
        while ((exp_q.size() != 0 || BUSY !== 1'b0) && guard < 300) begin
            step();
            guard++;
        end
        tests++;
        if (exp_q.size() != 0 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL drain: %0d packets outstanding, BUSY=%b, required 0 and 0", exp_q.size(), BUSY);
        end
    endtask

    // Wait (bounded) for the next strobe; returns its cycle or -1
    task automatic wait_strobe(input string name, output int scyc);
        int guard;
        guard = 0;
        while (DATA_VAL !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        tests++;
        if (DATA_VAL !== 1'b1) begin
            fails++;
            $display("FAIL %s: no DATA_VAL within %0d cycles, required a strobe", name, guard);
            scyc = -1;
        end else begin
            scyc = cyc;
        end
    endtask

    task automatic test_reset();
        RESET     = 1'b1;
        UPD_VALID = 1'b0;
        UPD_X     = '0;
        UPD_Y     = '0;
        UPD_DATA  = '0;
        repeat (3) step();
        tests++;
        if (DATA_VAL !== 1'b0) begin fails++; $display("FAIL reset_val: DATA_VAL=%b, required 0", DATA_VAL); end
        tests++;
        if (DATA_OUT !== 16'h0000) begin fails++; $display("FAIL reset_out: DATA_OUT=%h, required 0000", DATA_OUT); end
        tests++;
        if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy: BUSY=%b, required 0", BUSY); end
        tests++;
        if (DROP_CNT !== 8'd0) begin fails++; $display("FAIL reset_drop: DROP_CNT=%0d, required 0", DROP_CNT); end
        RESET = 1'b0;
        step();
        tests++;
        if (UPD_READY !== 1'b1) begin fails++; $display("FAIL reset_ready: UPD_READY=%b, required 1", UPD_READY); end
    endtask

    // Update accepted at posedge N (FIFO empty, idle): the pop edge is N+1,
    // so DATA_VAL is high in the cycle following posedge N+1, two cycles after
    // the cycle that ended with the accepting edge.
    task automatic test_single();
        int acc;
        int scyc;
        send(3'd2, 2'd1, 8'h02, 1'b0, acc);
        UPD_VALID = 1'b0;
        wait_strobe("single_strobe", scyc);
        if (scyc >= 0) begin
            tests++;
            if (scyc !== acc + 1) begin
                fails++;
                $display("FAIL single_latency: strobe after edge %0d, required edge %0d", scyc, acc + 1);
            end
            tests++;
            if (DATA_OUT !== 16'h4802) begin fails++; $display("FAIL single_data: DATA_OUT=%h, required 4802", DATA_OUT); end
            step();
            tests++;
            if (DATA_VAL !== 1'b0) begin fails++; $display("FAIL single_width: DATA_VAL=%b one cycle later, required 0", DATA_VAL); end
            tests++;
            if (DATA_OUT !== 16'h4802) begin fails++; $display("FAIL single_hold: DATA_OUT=%h after strobe, required 4802", DATA_OUT); end
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int acc;
        strobe_cyc_q.delete();
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (UPD_READY !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready: UPD_READY=%b before update %0d, required 1", UPD_READY, k);
            end
            send(3'(k % 5), 2'((k / 5) % 4), 8'(8'h10 + k), 1'b0, acc);
        end
        wait_idle();
        tests++;
        if (strobe_cyc_q.size() != 8) begin
            fails++;
            $display("FAIL b2b_count: %0d strobes, required 8", strobe_cyc_q.size());
        end else begin
            for (int i = 1; i < 8; i++) begin
                tests++;
                if (strobe_cyc_q[i] - strobe_cyc_q[i-1] != 4) begin
                    fails++;
                    $display("FAIL b2b_spacing: strobes %0d and %0d are %0d cycles apart, required 4",
                             i - 1, i, strobe_cyc_q[i] - strobe_cyc_q[i-1]);
                end
            end
        end
    endtask

    // Push continuously faster than the link drains; FIFO occupancy is
    // accepted minus popped, and a pop is visible as a strobe right after it.
    task automatic test_fifo_full();
        int  base;
        int  acc;
        int  k;
        int  guard;
        bit  saw_low;
        logic exp_ready;
        base    = strobe_cnt;
        acc     = 0;
        k       = 0;
        guard   = 0;
        saw_low = 1'b0;
        while (k < 16 && guard < 200) begin
            UPD_VALID = 1'b1;
            UPD_X     = 3'(k % 5);
            UPD_Y     = 2'(k % 4);
            UPD_DATA  = 8'(8'h40 + k);
            exp_ready = ((acc - (strobe_cnt - base)) < 8);
            tests++;
            if (UPD_READY !== exp_ready) begin
                fails++;
                $display("FAIL full_ready: UPD_READY=%b with %0d queued, required %b",
                         UPD_READY, acc - (strobe_cnt - base), exp_ready);
            end
            if (UPD_READY === 1'b0) saw_low = 1'b1;
            if (UPD_READY === 1'b1) begin
                exp_q.push_back(pack(UPD_X, UPD_Y, UPD_DATA));
                acc++;
                k++;
            end
            step();
            guard++;
        end
        wait_idle();
        tests++;
        if (!saw_low) begin fails++; $display("FAIL full_backpressure: UPD_READY low seen=%b, required 1", saw_low); end
        tests++;
        if (strobe_cnt - base != 16) begin
            fails++;
            $display("FAIL full_count: %0d packets, required 16", strobe_cnt - base);
        end
    endtask

    task automatic test_range();
        int acc;
        int base;
        base = strobe_cnt;
        send(3'd5, 2'd0, 8'h33, 1'b0, acc);
        send(3'd0, 2'd3, 8'h06, 1'b0, acc);
        send(3'd4, 2'd3, 8'h81, 1'b0, acc);
        wait_idle();
        tests++;
        if (DROP_CNT !== 8'(exp_drop)) begin
            fails++;
            $display("FAIL range_drop: DROP_CNT=%0d, required %0d", DROP_CNT, exp_drop);
        end
        tests++;
        if (strobe_cnt - base != 2) begin
            fails++;
            $display("FAIL range_count: %0d packets, required 2", strobe_cnt - base);
        end
    endtask

    task automatic test_drop_saturate();
        int acc;
        for (int i = 0; i < 270; i++) begin
            send(3'd7, 2'(i % 4), 8'(i), 1'b0, acc);
            if (i == 99) begin
                tests++;
                if (DROP_CNT !== 8'(exp_drop)) begin
                    fails++;
                    $display("FAIL drop_mid: DROP_CNT=%0d, required %0d", DROP_CNT, exp_drop);
                end
            end
        end
        UPD_VALID = 1'b0;
        step();
        tests++;
        if (DROP_CNT !== 8'd255) begin fails++; $display("FAIL drop_saturate: DROP_CNT=%0d, required 255", DROP_CNT); end
        tests++;
        if (BUSY !== 1'b0) begin fails++; $display("FAIL drop_busy: BUSY=%b, required 0", BUSY); end
    endtask

    task automatic test_reset_mid_packet();
        int acc;
        int scyc;
        int base;
        send(3'd2, 2'd2, 8'h51, 1'b0, acc);
        send(3'd3, 2'd0, 8'h52, 1'b0, acc);
        send(3'd1, 2'd3, 8'h53, 1'b0, acc);
        UPD_VALID = 1'b0;
        wait_strobe("mid_strobe", scyc);
        #1;
        RESET = 1'b1;
        #1;
        exp_q.delete();
        exp_drop = 0;
        tests++;
        if (DATA_VAL !== 1'b0) begin fails++; $display("FAIL mid_val: DATA_VAL=%b during reset, required 0", DATA_VAL); end
        tests++;
        if (DATA_OUT !== 16'h0000) begin fails++; $display("FAIL mid_out: DATA_OUT=%h during reset, required 0000", DATA_OUT); end
        tests++;
        if (BUSY !== 1'b0) begin fails++; $display("FAIL mid_busy: BUSY=%b during reset, required 0", BUSY); end
        tests++;
        if (DROP_CNT !== 8'd0) begin fails++; $display("FAIL mid_drop: DROP_CNT=%0d during reset, required 0", DROP_CNT); end
        step();
        RESET = 1'b0;
        base  = strobe_cnt;
        repeat (6) step();
        tests++;
        if (strobe_cnt != base || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL mid_flush: %0d strobes, BUSY=%b after reset, required 0 and 0", strobe_cnt - base, BUSY);
        end
        send(3'd3, 2'd2, 8'h77, 1'b0, acc);
        UPD_VALID = 1'b0;
        wait_strobe("mid_restart", scyc);
        if (scyc >= 0) begin
            tests++;
            if (scyc !== acc + 1) begin
                fails++;
                $display("FAIL mid_latency: strobe after edge %0d, required edge %0d", scyc, acc + 1);
            end
        end
        wait_idle();
    endtask

    task automatic test_dedup();
        int acc;
        int base;
        int exp_cnt;
        base = strobe_cnt;
        send(3'd1, 2'd1, 8'h04, 1'b0, acc);
`ifdef MAZE_TX_DEDUP_EN
        send(3'd1, 2'd1, 8'h04, 1'b1, acc);
        exp_cnt = 2;
`else
        send(3'd1, 2'd1, 8'h04, 1'b0, acc);
        exp_cnt = 3;
`endif
        send(3'd1, 2'd1, 8'h06, 1'b0, acc);
        wait_idle();
        tests++;
        if (strobe_cnt - base != exp_cnt) begin
            fails++;
            $display("FAIL dedup_count: %0d packets, required %0d", strobe_cnt - base, exp_cnt);
        end
        tests++;
        if (DROP_CNT !== 8'd0) begin fails++; $display("FAIL dedup_drop: DROP_CNT=%0d, required 0", DROP_CNT); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests      = 0;
        fails      = 0;
        strobe_cnt = 0;
        exp_drop   = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_range();
        test_drop_saturate();
        test_reset_mid_packet();
        test_dedup();
        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
